// File: rtl/kp_pkg.sv
// ------------------------------------------------------------------
// kp_pkg : shared constants and FSM encoding for the kernel path
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package kp_pkg;

  localparam int NUM_LINEBUF = 4;
  localparam int KERNEL_DIM  = 3;
  localparam int WIN_PIXELS  = KERNEL_DIM * KERNEL_DIM;
  localparam int SEL_W       = $clog2(NUM_LINEBUF);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } kp_state_e;

endpackage

`default_nettype wire

// File: rtl/kp_linebuffer.sv
// ------------------------------------------------------------------
// kp_linebuffer : one line of pixels, registered {left,centre,right} read
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module kp_linebuffer #(
  parameter int LINE_LENGTH = 640,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rstn,
  input  logic                           i_wr,
  input  logic [$clog2(LINE_LENGTH)-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0]          i_wr_data,
  input  logic                           i_rd,
  input  logic [$clog2(LINE_LENGTH)-1:0] i_rd_addr,
  output logic [3*DATA_WIDTH-1:0]        o_data
);

  localparam int AW = $clog2(LINE_LENGTH);
  localparam logic [AW-1:0] LAST_COL = AW'(LINE_LENGTH - 1);

  logic [DATA_WIDTH-1:0]   mem_q [LINE_LENGTH];
  logic [3*DATA_WIDTH-1:0] data_q;
  logic [AW-1:0]           w_left_addr;
  logic [AW-1:0]           w_right_addr;

  // Horizontal neighbours wrap around the line; downstream masks them.
  always_comb begin
    w_left_addr  = (i_rd_addr == '0)       ? LAST_COL : i_rd_addr - AW'(1);
    w_right_addr = (i_rd_addr == LAST_COL) ? '0       : i_rd_addr + AW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_wr) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      data_q <= '0;
    end else if (i_rd) begin
      data_q <= {mem_q[w_left_addr], mem_q[i_rd_addr], mem_q[w_right_addr]};
    end
  end

  assign o_data = data_q;

endmodule

`default_nettype wire

// File: rtl/kp_window_ctrl.sv
// ------------------------------------------------------------------
// kp_window_ctrl : 3x3 window generator over four rotating line buffers
// Optional macro KP_WINDOW_OVF_DET_EN adds sticky o_overflow. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module kp_window_ctrl
  import kp_pkg::*;
#(
  parameter int LINE_LENGTH = 640,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rstn,
  input  logic                           i_valid,
  input  logic [DATA_WIDTH-1:0]          i_data,
  output logic                           o_valid,
  output logic [WIN_PIXELS*DATA_WIDTH-1:0] o_data,
  output logic                           o_sol,
  output logic                           o_eol
`ifdef KP_WINDOW_OVF_DET_EN
  , output logic                         o_overflow
`endif
);

  localparam int COL_W = $clog2(LINE_LENGTH);
  localparam int CNT_W = $clog2(NUM_LINEBUF * LINE_LENGTH + 1);
  localparam int ROW_W = KERNEL_DIM * DATA_WIDTH;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_LENGTH - 1);
  localparam logic [CNT_W-1:0] LINE_CNT = CNT_W'(LINE_LENGTH);
  localparam logic [CNT_W-1:0] READ_LVL = CNT_W'(KERNEL_DIM * LINE_LENGTH);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(NUM_LINEBUF * LINE_LENGTH);

  kp_state_e          state_q, state_d;
  logic [SEL_W-1:0]   wr_sel_q, wr_sel_d;
  logic [COL_W-1:0]   wr_col_q, wr_col_d;
  logic [SEL_W-1:0]   rd_sel_q, rd_sel_d;
  logic [COL_W-1:0]   rd_col_q, rd_col_d;
  logic [CNT_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic               valid_q, sol_q, eol_q;
  logic [SEL_W-1:0]   out_sel_q;

  logic               w_wr_en;
  logic               w_rd_en;
  logic               w_rd_last;
  logic [NUM_LINEBUF-1:0] w_buf_wr;
  logic [NUM_LINEBUF-1:0] w_buf_rd;
  logic [ROW_W-1:0]   w_buf_data [NUM_LINEBUF];
  logic [SEL_W-1:0]   w_sel_mid;
  logic [SEL_W-1:0]   w_sel_bot;

`ifdef KP_WINDOW_OVF_DET_EN
  logic ovf_q;
  logic w_full;

  // A write arriving with all four lines occupied is dropped entirely.
  assign w_full  = (fill_cnt_q == FULL_LVL);
  assign w_wr_en = i_valid & ~w_full;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      ovf_q <= 1'b0;
    end else if (i_valid && w_full) begin
      ovf_q <= 1'b1;
    end
  end

  assign o_overflow = ovf_q;
`else
  assign w_wr_en = i_valid;
`endif

  always_comb begin
    state_d    = state_q;
    wr_sel_d   = wr_sel_q;
    wr_col_d   = wr_col_q;
    rd_sel_d   = rd_sel_q;
    rd_col_d   = rd_col_q;
    w_rd_en    = (state_q == READ);
    w_rd_last  = w_rd_en && (rd_col_q == LAST_COL);
    fill_cnt_d = fill_cnt_q + CNT_W'(w_wr_en) - (w_rd_last ? LINE_CNT : '0);

    if (w_wr_en) begin
      if (wr_col_q == LAST_COL) begin
        wr_col_d = '0;
        wr_sel_d = wr_sel_q + SEL_W'(1);
      end else begin
        wr_col_d = wr_col_q + COL_W'(1);
      end
    end

    if (w_rd_en) begin
      if (w_rd_last) begin
        rd_col_d = '0;
        rd_sel_d = rd_sel_q + SEL_W'(1);
      end else begin
        rd_col_d = rd_col_q + COL_W'(1);
      end
    end

    // Decision at end of line uses the post-update count, so lines run back to back.
    case (state_q)
      IDLE:    if (fill_cnt_q >= READ_LVL) state_d = READ;
      READ:    if (w_rd_last && (fill_cnt_d < READ_LVL)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      wr_sel_q   <= '0;
      wr_col_q   <= '0;
      rd_sel_q   <= '0;
      rd_col_q   <= '0;
      fill_cnt_q <= '0;
      valid_q    <= 1'b0;
      sol_q      <= 1'b0;
      eol_q      <= 1'b0;
      out_sel_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_sel_q   <= wr_sel_d;
      wr_col_q   <= wr_col_d;
      rd_sel_q   <= rd_sel_d;
      rd_col_q   <= rd_col_d;
      fill_cnt_q <= fill_cnt_d;
      valid_q    <= w_rd_en;
      sol_q      <= w_rd_en && (rd_col_q == '0);
      eol_q      <= w_rd_last;
      if (w_rd_en) begin
        out_sel_q <= rd_sel_q;
      end
    end
  end

  for (genvar n = 0; n < NUM_LINEBUF; n++) begin : g_linebuf
    logic [SEL_W-1:0] w_rel;

    // Read the three buffers at offsets 0..2 from the oldest line.
    assign w_rel       = SEL_W'(n) - rd_sel_q;
    assign w_buf_wr[n] = w_wr_en & (wr_sel_q == SEL_W'(n));
    assign w_buf_rd[n] = w_rd_en & (w_rel < SEL_W'(KERNEL_DIM));

    kp_linebuffer #(
      .LINE_LENGTH (LINE_LENGTH),
      .DATA_WIDTH  (DATA_WIDTH)
    ) u_linebuf (
      .i_clk     (i_clk),
      .i_rstn    (i_rstn),
      .i_wr      (w_buf_wr[n]),
      .i_wr_addr (wr_col_q),
      .i_wr_data (i_data),
      .i_rd      (w_buf_rd[n]),
      .i_rd_addr (rd_col_q),
      .o_data    (w_buf_data[n])
    );
  end

  always_comb begin
    w_sel_mid = out_sel_q + SEL_W'(1);
    w_sel_bot = out_sel_q + SEL_W'(2);
    o_data    = {w_buf_data[out_sel_q], w_buf_data[w_sel_mid], w_buf_data[w_sel_bot]};
  end

  assign o_valid = valid_q;
  assign o_sol   = sol_q;
  assign o_eol   = eol_q;

endmodule

`default_nettype wire

// File: tb/tb_kp_window_ctrl.sv
// ------------------------------------------------------------------
// tb_kp_window_ctrl : directed self-checking bench, LINE_LENGTH=4
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_kp_window_ctrl;

  localparam int LL = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          valid_out;
  logic [9*DW-1:0] data_out;
  logic          sol, eol;
`ifdef KP_WINDOW_OVF_DET_EN
  logic          overflow;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nwin, win_line, win_col, first_cyc, last_cyc, sol_cyc, w12_cyc;

  always #5 clk = ~clk;

  kp_window_ctrl #(.LINE_LENGTH(LL), .DATA_WIDTH(DW)) dut (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_valid (valid_in),
    .i_data  (data_in),
    .o_valid (valid_out),
    .o_data  (data_out),
    .o_sol   (sol),
    .o_eol   (eol)
`ifdef KP_WINDOW_OVF_DET_EN
    , .o_overflow (overflow)
`endif
  );

  function automatic logic [7:0] px(input int r, input int c);
    return 8'(r * 16 + c);
  endfunction

  function automatic logic [9*DW-1:0] win(input int r, input int c);
    int l, rr;
    l  = (c + LL - 1) % LL;
    rr = (c + 1) % LL;
    return {px(r, l), px(r, c), px(r, rr),
            px(r + 1, l), px(r + 1, c), px(r + 1, rr),
            px(r + 2, l), px(r + 2, c), px(r + 2, rr)};
  endfunction

  task automatic chk(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_mon();
    nwin = 0; win_line = 0; win_col = 0;
    first_cyc = -1; last_cyc = -1; sol_cyc = -1; w12_cyc = -1;
  endtask

  // One clock; samples outputs 1 time unit after the edge and checks any window.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (valid_out === 1'b1) begin
      chk($sformatf("win_l%0d_c%0d", win_line, win_col), data_out, win(win_line, win_col));
      chk("sol", 72'(sol), 72'(win_col == 0));
      chk("eol", 72'(eol), 72'(win_col == LL - 1));
      if (sol === 1'b1) sol_cyc = cyc;
      if (eol === 1'b1) chk("burst_len", 72'(cyc - sol_cyc), 72'(LL - 1));
      if (nwin == 0) first_cyc = cyc;
      last_cyc = cyc;
      nwin++;
      if (win_col == LL - 1) begin
        win_col = 0;
        win_line++;
      end else begin
        win_col++;
      end
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; valid_in = 1'b0; data_in = '0;
    tick(); tick();
    rstn = 1'b1;
    clear_mon();
  endtask

  task automatic feed(input int npix, input bit toggle);
    for (int i = 0; i < npix; i++) begin
      valid_in = 1'b1;
      data_in  = px(i / LL, i % LL);
      tick();
      if (i == 3 * LL - 1) w12_cyc = cyc;
      if (i < 3 * LL - 1) chk("early_valid", 72'(nwin), 72'(0));
      if (toggle) begin
        valid_in = 1'b0;
        tick();
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic scenario1(input string pfx);
    feed(12, 1'b0);
    drain(12);
    chk({pfx, "_nwin"}, 72'(nwin), 72'(4));
    chk({pfx, "_first_lat"}, 72'(first_cyc - w12_cyc), 72'(2));
    chk({pfx, "_contig"}, 72'(last_cyc - first_cyc), 72'(3));
  endtask

  initial begin
    rstn = 1'b0; valid_in = 1'b0; data_in = '0;
    clear_mon();

    // Reset state
    do_reset();
    chk("rst_valid", 72'(valid_out), 72'(0));
    chk("rst_sol", 72'(sol), 72'(0));
    chk("rst_eol", 72'(eol), 72'(0));
    chk("rst_data", data_out, 72'(0));

    // Three lines, continuous
    chk("s1_first_win", win(0, 0), 72'h03_00_01_13_10_11_23_20_21);
    scenario1("s1");

    // Six lines, continuous: four back-to-back output lines, buffer select wraps
    do_reset();
    feed(24, 1'b0);
    drain(16);
    chk("s2_nwin", 72'(nwin), 72'(16));
    chk("s2_contig", 72'(last_cyc - first_cyc), 72'(15));
    chk("s2_lines", 72'(win_line), 72'(4));
    chk("s2_rd_sel_wrap", 72'(dut.rd_sel_q), 72'(0));

    // Six lines with i_valid toggling
    do_reset();
    feed(24, 1'b1);
    drain(20);
    chk("s3_nwin", 72'(nwin), 72'(16));
    chk("s3_lines", 72'(win_line), 72'(4));

    // Reset during the second window of the first output line
    do_reset();
    feed(12, 1'b0);
    for (int i = 0; i < 10 && nwin < 2; i++) tick();
    chk("s4_reached_win2", 72'(nwin), 72'(2));
    rstn = 1'b0;
    tick();
    chk("s4_rst_valid", 72'(valid_out), 72'(0));
    chk("s4_rst_data", data_out, 72'(0));
    rstn = 1'b1;
    clear_mon();
    scenario1("s4");

    // Five lines: writes coincide with end-of-line reads
    do_reset();
    feed(20, 1'b0);
    drain(20);
    chk("s5_nwin", 72'(nwin), 72'(12));
    chk("s5_contig", 72'(last_cyc - first_cyc), 72'(11));

`ifdef KP_WINDOW_OVF_DET_EN
    do_reset();
    force dut.state_q = kp_pkg::IDLE;
    feed(16, 1'b0);
    chk("ovf_before", 72'(overflow), 72'(0));
    chk("ovf_fill16", 72'(dut.fill_cnt_q), 72'(16));
    valid_in = 1'b1;
    data_in  = 8'hAA;
    tick();
    valid_in = 1'b0;
    chk("ovf_set", 72'(overflow), 72'(1));
    chk("ovf_fill_hold", 72'(dut.fill_cnt_q), 72'(16));
    chk("ovf_wr_col_hold", 72'(dut.wr_col_q), 72'(0));
    chk("ovf_wr_sel_hold", 72'(dut.wr_sel_q), 72'(0));
    tick();
    chk("ovf_sticky", 72'(overflow), 72'(1));
    release dut.state_q;
    do_reset();
    chk("ovf_rst_clear", 72'(overflow), 72'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/kp_window_ctrl.md
Name: kp_window_ctrl

Overview:
- Streaming 3x3 kernel window generator for the colour-detect kernel-processing path.
- Accepts a raster pixel stream, one pixel per cycle maximum, and writes it round-robin into four kp_linebuffer instances.
- Once three complete lines are buffered, reads the three oldest lines in lockstep and emits one 72-bit 3x3 window per cycle to the downstream kernel datapath.

Parameters:
- LINE_LENGTH, 640, pixels per line; also the depth of each line buffer.
- DATA_WIDTH, 8, bits per pixel.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset, synchronous, active-low.
- i_valid  in  1  input pixel strobe.
- i_data  in  DATA_WIDTH  input pixel.
- o_valid  out  1  window valid.
- o_data  out  9*DATA_WIDTH  window: {top[3*DW], mid[3*DW], bot[3*DW]}; each row is {left, centre, right}.
- o_sol  out  1  first window of an output line, qualified by o_valid.
- o_eol  out  1  last window of an output line, qualified by o_valid.

Behaviour:
- Reset: o_valid, o_sol, o_eol = 0; o_data = 0. Internal wr_sel, wr_col, rd_sel, rd_col, fill_cnt = 0. State = IDLE.
- Write side:
  - i_valid writes i_data into buffer wr_sel and increments wr_col.
  - At wr_col == LINE_LENGTH-1, wr_col wraps to 0 and wr_sel increments mod 4.
  - Writes are never stalled.
- fill_cnt:
  - Counts buffered, unconsumed pixels; width clog2(4*LINE_LENGTH+1).
  - +1 per write; -LINE_LENGTH on the last read of a line.
  - When both happen in the same cycle, the net change is 1-LINE_LENGTH.
- FSM IDLE -> READ:
  - Transition when fill_cnt >= 3*LINE_LENGTH.
- FSM READ:
  - Each cycle, asserts i_rd to buffers rd_sel, rd_sel+1 and rd_sel+2 (mod 4).
  - rd_col counts 0..LINE_LENGTH-1.
  - On rd_col == LINE_LENGTH-1:
    - rd_sel increments mod 4 and fill_cnt is decremented.
    - Next state is READ if post-update fill_cnt >= 3*LINE_LENGTH, else IDLE.
    - No bubble between back-to-back lines.
- Latency:
  - Line buffers have 1-cycle read latency.
  - o_valid is the read strobe registered once; o_sol is (rd_col==0) registered; o_eol is (rd_col==LINE_LENGTH-1) registered.
  - A window is emitted 1 cycle after its read strobe.
- Row mapping: top = buffer rd_sel (oldest line), mid = rd_sel+1, bot = rd_sel+2.
  - The buffer selection used for o_data is the registered rd_sel, so it stays aligned with the 1-cycle read latency.
- Horizontal edges:
  - Column 0 window left pixel = column LINE_LENGTH-1 of the same line.
  - Column LINE_LENGTH-1 right pixel = column 0.
  - The wrapped pixels are passed unmodified; the downstream stage masks them using o_sol/o_eol.
- Capacity:
  - With input rate <= 1 pixel/cycle, fill_cnt never exceeds 4*LINE_LENGTH.
  - Writing into the buffer being read cannot occur while read proceeds at 1 window/cycle.
- Reset mid-frame:
  - All pointers, counters and the FSM return to their reset values.
  - Buffer contents are stale but are ignored until refilled.
- Vertical edges: no padding rows are generated; N input lines yield N-2 output lines.

Optional Feature:
- Macro: KP_WINDOW_OVF_DET_EN.
- Defined:
  - Adds output o_overflow (1 bit), reset 0.
  - Set sticky when i_valid is asserted while fill_cnt == 4*LINE_LENGTH.
  - The offending write is dropped: no buffer write and no counter update.
  - Cleared only by reset.
- Undefined: no port and no check; writes are unconditional.

Decomposition:
- Shared package kp_pkg:
  - Constant NUM_LINEBUF = 4.
  - Constant KERNEL_DIM = 3.
  - Window width localparam 9*DATA_WIDTH.
  - FSM state encoding IDLE/READ.
- Sub-module: four instances of the existing kp_linebuffer, generated in a loop.
  - Per-buffer i_wr = i_valid & (wr_sel == n).
  - Per-buffer i_rd is decoded from rd_sel while in READ.
  - Per-buffer 3*DW output, mux-rotated by the registered rd_sel.

Test Plan (LINE_LENGTH=4, DATA_WIDTH=8, pixel = row*16+col):
- Three lines (12 pixels) continuous:
  - No o_valid before the 12th write.
  - The first o_valid arrives exactly 2 cycles after the 12th write, with o_sol=1.
  - Its top row = {03,00,01}, mid = {13,10,11}, bot = {23,20,21}.
  - o_valid is high for 4 consecutive cycles; o_eol=1 on the 4th.
- Six lines continuous:
  - Four output lines, no bubbles between them.
  - Fourth line top = row 3, bot = row 5.
  - Buffer rotation wraps: top buffer index 3, then 0.
- Input with i_valid toggling 1/0:
  - Windows are identical to the continuous case.
  - Output lines are bursts of 4 cycles, each started when fill_cnt reaches 12.
- Reset asserted mid-read (second output window):
  - o_valid = 0 the next cycle.
  - After reset, a fresh 12-pixel feed reproduces scenario 1 exactly.
- Write on the same cycle as the last read of a line: fill_cnt changes by exactly -3, checked via window count over a 5-line stream (3 windows lines total).
- With KP_WINDOW_OVF_DET_EN: hold the FSM idle by forcing, feed 17 pixels.
  - o_overflow rises on the 17th write.
  - Pixel 17 is not stored.
